intra_ref_addr_gen: RTL and testbench
=====================================

INTRA_REF_ADDR_GEN -- requirements
Module: intra_ref_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: reference-address width.
REQ-002 SHALL have parameter TILE, default 4: tile side; LANES = TILE*TILE pixels per beat.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: begin block; samples mode_angle and log2_size.
REQ-006 SHALL have port mode_angle, input, 1: 1 = angular, 0 = planar.
REQ-007 SHALL have port log2_size, input, 3: block size N = 2^log2_size.
REQ-008 SHALL have port in_valid, input, 1: angular beat offered.
REQ-009 SHALL have port in_ready, output, 1: angular beat accepted when in_valid && in_ready.
REQ-010 SHALL have port ang_tol, input, LANES: per-lane top(1)/left(0) select, angular.
REQ-011 SHALL have port ang_addr, input, LANES*ADDR_W: per-lane base address, lane k at bits [k*ADDR_W +: ADDR_W], lane k = row k/TILE, col k%TILE.
REQ-012 SHALL have ports tol1 and tol2, output, LANES each: per-lane array select for the first and second reference sample.
REQ-013 SHALL have ports addr1 and addr2, output, LANES*ADDR_W each: per-lane first and second reference addresses.
REQ-014 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_last (output, 1): last tile of block.
REQ-015 SHALL have port busy, output, 1: high from accepted start until last beat is handed off.

Function
REQ-016 SHALL implement FSM IDLE->RUN on start in IDLE; start in RUN ignored.
REQ-017 SHALL clamp effective log2_size to [log2(TILE), 5]; tiles per block = (N/TILE)^2, raster order, tile counters tx,ty.
REQ-018 SHALL register outputs in one output stage; beat appears on out_valid the cycle after generation/acceptance (latency 1).
REQ-019 SHALL drive in_ready = RUN && mode_angle && (!out_valid || out_ready); 0 in IDLE and in planar.
REQ-020 In planar mode SHALL self-generate one beat per cycle while !out_valid || out_ready; in_valid ignored.
REQ-021 Planar lane (r,c) SHALL output tol1=1, addr1=tx*TILE+c, tol2=0, addr2=ty*TILE+r.
REQ-022 Angular lane SHALL output tol1=tol2=ang_tol[k], addr1=ang_addr[k], addr2=ang_addr[k]+1 modulo 2^ADDR_W.
REQ-023 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-024 SHALL assert out_last with the beat of tile (N/TILE-1, N/TILE-1); after its handoff return to IDLE, busy=0 the following cycle.
REQ-025 SHALL accept start in the same cycle the last beat is handed off (back-to-back blocks, no bubble in FSM).

Reset
REQ-026 On rst_n low SHALL force IDLE, tx=ty=0, out_valid=0, out_last=0, busy=0, in_ready=0, all tol/addr outputs 0, immediately and regardless of clk.
REQ-027 Reset mid-block SHALL discard the block; first cycle after release behaves as IDLE.

Configuration
REQ-028 With INTRA_ADDR_CLAMP_EN defined, angular addr1 and addr2 SHALL saturate at 2N (last valid reference index).
REQ-029 Without INTRA_ADDR_CLAMP_EN, addresses SHALL follow REQ-022 unmodified; planar unaffected in both cases.

Structure
REQ-030 SHALL place FSM state encoding, TILE default and max log2 size (5) in shared package intra_pkg.
REQ-031 SHALL use one sub-module intra_tile_cnt (tx/ty raster counter, last-tile flag).

Verification
REQ-032 Planar, log2_size=2, out_ready=1: start -> one beat next cycle, addr1 lanes row-wise 0,1,2,3, addr2 rows 0,1,2,3, tol1=1, tol2=0, out_last=1.
REQ-033 Planar, log2_size=3: 4 beats consecutive cycles; beat 3 (tx=1,ty=1) lane 0 addr1=4, addr2=4, out_last only on beat 3.
REQ-034 Angular, log2_size=2, ang_addr all 8'hFF: with INTRA_ADDR_CLAMP_EN addr1=addr2=8; without, addr1=255, addr2=0.
REQ-035 Angular, out_ready held 0 for 3 cycles after first beat: in_ready=0, outputs stable, no beat lost or duplicated.
REQ-036 Planar log2_size=5, rst_n pulsed low at beat 10: outputs zero immediately, busy=0; new start restarts at tx=ty=0.
REQ-037 start asserted on last-beat handoff cycle: next block's first beat follows with no gap; log2_size=1 input treated as 2.

Source files
------------

// File: rtl/intra_pkg.sv
// Shared types and limits for the intra reference-address generator.
package intra_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StLast
    } state_e;

    localparam int unsigned TILE_DEF = 4;
    localparam int unsigned MAX_LOG2 = 5;

    function automatic logic [2:0] clamp_l2(input logic [2:0] l2, input int unsigned lo);
        logic [2:0] v;
        v = l2;
        if (32'(l2) < lo) begin
            v = 3'(lo);
        end else if (32'(l2) > MAX_LOG2) begin
            v = 3'(MAX_LOG2);
        end
        return v;
    endfunction

endpackage

// File: rtl/intra_tile_cnt.sv
// Raster tile counter (tx fastest) with a combinational last-tile flag.
// i_clr restarts the block at tile (0,0) in the same cycle it may be consumed.
module intra_tile_cnt
    import intra_pkg::*;
#(
    parameter int unsigned TILE  = TILE_DEF,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_adv,
    input  logic [2:0]       i_l2,
    output logic [CNT_W-1:0] o_tx,
    output logic [CNT_W-1:0] o_ty,
    output logic             o_last
);

    localparam int unsigned LOG2_TILE = $clog2(TILE);

    logic [CNT_W-1:0] r_tx;
    logic [CNT_W-1:0] r_ty;
    logic [CNT_W-1:0] w_tx_nxt;
    logic [CNT_W-1:0] w_ty_nxt;
    logic [CNT_W-1:0] w_side_m1;

    always_comb begin
        // i_l2 is already clamped to at least LOG2_TILE, so the shift is non-negative
        w_side_m1 = CNT_W'((32'd1 << (32'(i_l2) - LOG2_TILE)) - 32'd1);
        o_tx      = i_clr ? '0 : r_tx;
        o_ty      = i_clr ? '0 : r_ty;
        o_last    = (o_tx == w_side_m1) && (o_ty == w_side_m1);
        w_tx_nxt  = o_tx;
        w_ty_nxt  = o_ty;
        if (i_adv) begin
            if (o_last) begin
                w_tx_nxt = '0;
                w_ty_nxt = '0;
            end else if (o_tx == w_side_m1) begin
                w_tx_nxt = '0;
                w_ty_nxt = o_ty + CNT_W'(1);
            end else begin
                w_tx_nxt = o_tx + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx <= '0;
            r_ty <= '0;
        end else begin
            r_tx <= w_tx_nxt;
            r_ty <= w_ty_nxt;
        end
    end

endmodule

// File: rtl/intra_ref_addr_gen.sv
// Per-tile intra reference address generator (planar self-generated, angular pass-through).
// Optional INTRA_ADDR_CLAMP_EN saturates angular addresses at 2N.
module intra_ref_addr_gen
    import intra_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned TILE   = TILE_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          mode_angle,
    input  logic [2:0]                    log2_size,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [TILE*TILE-1:0]          ang_tol,
    input  logic [TILE*TILE*ADDR_W-1:0]   ang_addr,
    output logic [TILE*TILE-1:0]          tol1,
    output logic [TILE*TILE-1:0]          tol2,
    output logic [TILE*TILE*ADDR_W-1:0]   addr1,
    output logic [TILE*TILE*ADDR_W-1:0]   addr2,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          busy
);

    localparam int unsigned LANES     = TILE * TILE;
    localparam int unsigned LOG2_TILE = $clog2(TILE);
    localparam int unsigned CNT_W     = (MAX_LOG2 > LOG2_TILE) ? MAX_LOG2 - LOG2_TILE : 1;

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic                      r_mode;
    logic [2:0]                r_l2;
    logic                      r_out_valid;
    logic                      r_out_last;
    logic [LANES-1:0]          r_tol1;
    logic [LANES-1:0]          r_tol2;
    logic [LANES*ADDR_W-1:0]   r_addr1;
    logic [LANES*ADDR_W-1:0]   r_addr2;

    logic                      w_handoff;
    logic                      w_slot_free;
    logic                      w_start_acc;
    logic                      w_mode;
    logic [2:0]                w_l2;
    logic                      w_gen;
    logic                      w_last;
    logic [CNT_W-1:0]          w_tx;
    logic [CNT_W-1:0]          w_ty;
    logic [LANES-1:0]          w_tol1;
    logic [LANES-1:0]          w_tol2;
    logic [LANES*ADDR_W-1:0]   w_addr1;
    logic [LANES*ADDR_W-1:0]   w_addr2;

`ifdef INTRA_ADDR_CLAMP_EN
    function automatic logic [ADDR_W-1:0] sat_addr(input logic [ADDR_W:0] v,
                                                   input logic [2:0] l2);
        logic [31:0] lim;
        lim = 32'd2 << l2;
        return (32'(v) > lim) ? ADDR_W'(lim) : v[ADDR_W-1:0];
    endfunction
`endif

    assign w_handoff   = r_out_valid && out_ready;
    assign w_slot_free = !r_out_valid || out_ready;
    // A new block may start while the previous last beat leaves (no bubble)
    assign w_start_acc = start && ((r_state == StIdle) || ((r_state == StLast) && w_handoff));
    assign w_mode      = w_start_acc ? mode_angle : r_mode;
    assign w_l2        = w_start_acc ? clamp_l2(log2_size, LOG2_TILE) : r_l2;
    assign in_ready    = (r_state == StRun) && r_mode && w_slot_free;
    // Planar emits its first tile in the start cycle; angular waits for in_valid
    assign w_gen       = ((r_state == StRun) && w_slot_free && (!r_mode || in_valid)) ||
                         (w_start_acc && !mode_angle);

    intra_tile_cnt #(
        .TILE  (TILE),
        .CNT_W (CNT_W)
    ) u_tile_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_start_acc),
        .i_adv  (w_gen),
        .i_l2   (w_l2),
        .o_tx   (w_tx),
        .o_ty   (w_ty),
        .o_last (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == StLast) && w_handoff) begin
            w_state_nxt = StIdle;
        end
        if (w_start_acc) begin
            w_state_nxt = StRun;
        end
        if (w_gen && w_last) begin
            w_state_nxt = StLast;
        end
    end

    always_comb begin
        w_tol1  = '0;
        w_tol2  = '0;
        w_addr1 = '0;
        w_addr2 = '0;
        for (int k = 0; k < LANES; k++) begin
            if (w_mode) begin
                w_tol1[k] = ang_tol[k];
                w_tol2[k] = ang_tol[k];
`ifdef INTRA_ADDR_CLAMP_EN
                w_addr1[k*ADDR_W +: ADDR_W] = sat_addr({1'b0, ang_addr[k*ADDR_W +: ADDR_W]}, w_l2);
                w_addr2[k*ADDR_W +: ADDR_W] = sat_addr({1'b0, ang_addr[k*ADDR_W +: ADDR_W]} +
                                                       (ADDR_W+1)'(1), w_l2);
`else
                w_addr1[k*ADDR_W +: ADDR_W] = ang_addr[k*ADDR_W +: ADDR_W];
                w_addr2[k*ADDR_W +: ADDR_W] = ang_addr[k*ADDR_W +: ADDR_W] + ADDR_W'(1);
`endif
            end else begin
                w_tol1[k] = 1'b1;
                w_addr1[k*ADDR_W +: ADDR_W] = ADDR_W'(32'(w_tx) * TILE + 32'(k) % TILE);
                w_addr2[k*ADDR_W +: ADDR_W] = ADDR_W'(32'(w_ty) * TILE + 32'(k) / TILE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_mode      <= 1'b0;
            r_l2        <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_tol1      <= '0;
            r_tol2      <= '0;
            r_addr1     <= '0;
            r_addr2     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_mode <= mode_angle;
                r_l2   <= w_l2;
            end
            if (w_gen) begin
                r_out_valid <= 1'b1;
                r_out_last  <= w_last;
                r_tol1      <= w_tol1;
                r_tol2      <= w_tol2;
                r_addr1     <= w_addr1;
                r_addr2     <= w_addr2;
            end else if (w_handoff) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign tol1      = r_tol1;
    assign tol2      = r_tol2;
    assign addr1     = r_addr1;
    assign addr2     = r_addr2;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_intra_ref_addr_gen.sv
// Self-checking bench for intra_ref_addr_gen: directed corner sequences, a vector table,
// and randomized traffic against a tile-level reference model.
module tb_intra_ref_addr_gen;

    localparam int ADDR_W = 8;
    localparam int TILE   = 4;
    localparam int LANES  = 16;

    logic                      clk;
    logic                      rst_n;
    logic                      start;
    logic                      mode_angle;
    logic [2:0]                log2_size;
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES-1:0]          ang_tol;
    logic [LANES*ADDR_W-1:0]   ang_addr;
    logic [LANES-1:0]          tol1;
    logic [LANES-1:0]          tol2;
    logic [LANES*ADDR_W-1:0]   addr1;
    logic [LANES*ADDR_W-1:0]   addr2;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;
    logic                      busy;

    typedef struct packed {
        logic [LANES-1:0]        tol1;
        logic [LANES-1:0]        tol2;
        logic [LANES*ADDR_W-1:0] addr1;
        logic [LANES*ADDR_W-1:0] addr2;
        logic                    last;
    } beat_t;

    typedef struct {
        bit         mode;
        logic [2:0] l2;
        bit         rand_bp;
        int         exp_beats;
    } vec_t;

    int    checks   = 0;
    int    failures = 0;
    int    n_out    = 0;
    int    ang_left = 0;
    int    cur_l2   = 2;
    beat_t exp_q[$];
    beat_t mon_e;
    beat_t mon_g;
    beat_t mon_a;
    int    m_a, m_a1, m_a2, m_lim;

    intra_ref_addr_gen #(
        .ADDR_W (ADDR_W),
        .TILE   (TILE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode_angle (mode_angle),
        .log2_size  (log2_size),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ang_tol    (ang_tol),
        .ang_addr   (ang_addr),
        .tol1       (tol1),
        .tol2       (tol2),
        .addr1      (addr1),
        .addr2      (addr2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, want self-termination");
        $fatal(1);
    end

    function automatic int eff_l2(input int l2);
        return (l2 < 2) ? 2 : ((l2 > 5) ? 5 : l2);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected planar beats for a whole block, raster over tiles
    task automatic push_planar(input int l2in);
        int    el2;
        int    side;
        beat_t b;
        el2  = eff_l2(l2in);
        side = 1 << (el2 - 2);
        for (int ty = 0; ty < side; ty++) begin
            for (int tx = 0; tx < side; tx++) begin
                b.tol1 = '1;
                b.tol2 = '0;
                for (int r = 0; r < TILE; r++) begin
                    for (int c = 0; c < TILE; c++) begin
                        b.addr1[(r*TILE+c)*ADDR_W +: ADDR_W] = 8'(tx * TILE + c);
                        b.addr2[(r*TILE+c)*ADDR_W +: ADDR_W] = 8'(ty * TILE + r);
                    end
                end
                b.last = (tx == side - 1) && (ty == side - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic rand_ang();
        ang_tol = 16'($urandom);
        for (int k = 0; k < 4; k++) ang_addr[k*32 +: 32] = $urandom;
    endtask

    task automatic wait_idle(input bit rand_bp, input bit drive_ang, input string nm);
        int cyc;
        cyc = 0;
        while (busy && cyc < 3000) begin
            out_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (drive_ang) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_ang();
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({nm, "_done"}, busy, 0);
    endtask

    task automatic run_block(input vec_t v, input string nm);
        int n0;
        int side;
        n0         = n_out;
        mode_angle = v.mode;
        log2_size  = v.l2;
        cur_l2     = eff_l2(int'(v.l2));
        side       = 1 << (cur_l2 - 2);
        if (v.mode) ang_left = side * side;
        else        push_planar(int'(v.l2));
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(v.rand_bp, v.mode, nm);
        chk({nm, "_beats"}, n_out - n0, v.exp_beats);
    endtask

    // Scoreboard on handoff; angular model beats are built from accepted inputs
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected: got addr1=%h want no beat", addr1);
            end else begin
                mon_e = exp_q.pop_front();
                mon_g = {tol1, tol2, addr1, addr2, out_last};
                if (mon_g !== mon_e) begin
                    failures++;
                    $display("FAIL beat_%0d: got t1=%h t2=%h a1=%h a2=%h last=%b want t1=%h t2=%h a1=%h a2=%h last=%b",
                             n_out, mon_g.tol1, mon_g.tol2, mon_g.addr1, mon_g.addr2, mon_g.last,
                             mon_e.tol1, mon_e.tol2, mon_e.addr1, mon_e.addr2, mon_e.last);
                end
            end
        end
        if (rst_n && in_valid && in_ready) begin
            m_lim = 2 << cur_l2;
            for (int k = 0; k < LANES; k++) begin
                m_a  = int'(ang_addr[k*ADDR_W +: ADDR_W]);
                m_a1 = m_a;
                m_a2 = (m_a + 1) % 256;
`ifdef INTRA_ADDR_CLAMP_EN
                m_a1 = (m_a < m_lim) ? m_a : m_lim;
                m_a2 = ((m_a + 1) < m_lim) ? m_a + 1 : m_lim;
`endif
                mon_a.tol1[k] = ang_tol[k];
                mon_a.tol2[k] = ang_tol[k];
                mon_a.addr1[k*ADDR_W +: ADDR_W] = 8'(m_a1);
                mon_a.addr2[k*ADDR_W +: ADDR_W] = 8'(m_a2);
            end
            ang_left--;
            mon_a.last = (ang_left == 0);
            exp_q.push_back(mon_a);
        end
    end

    initial begin
        vec_t vt[11];
        int   n0;
        int   cyc;

        vt[0]  = '{1'b0, 3'd0, 1'b0, 1};
        vt[1]  = '{1'b0, 3'd1, 1'b1, 1};
        vt[2]  = '{1'b0, 3'd2, 1'b1, 1};
        vt[3]  = '{1'b0, 3'd3, 1'b1, 4};
        vt[4]  = '{1'b0, 3'd4, 1'b1, 16};
        vt[5]  = '{1'b0, 3'd5, 1'b1, 64};
        vt[6]  = '{1'b0, 3'd7, 1'b0, 64};
        vt[7]  = '{1'b1, 3'd2, 1'b1, 1};
        vt[8]  = '{1'b1, 3'd3, 1'b1, 4};
        vt[9]  = '{1'b1, 3'd4, 1'b1, 16};
        vt[10] = '{1'b1, 3'd6, 1'b1, 64};

        rst_n = 1'b0; start = 1'b0; mode_angle = 1'b0; log2_size = 3'd2;
        in_valid = 1'b0; out_ready = 1'b1; ang_tol = '0; ang_addr = '0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_addr1", addr1, 0);
        chk("rst_addr2", addr2, 0);
        chk("rst_tol1", {tol1, tol2}, 0);
        #10 rst_n = 1'b1;
        tick();

        // Planar 4x4: single beat, latency 1
        n0 = n_out; push_planar(2); mode_angle = 1'b0; log2_size = 3'd2; cur_l2 = 2;
        start = 1'b1; tick(); start = 1'b0;
        chk("p4_valid", out_valid, 1);
        chk("p4_last", out_last, 1);
        chk("p4_busy", busy, 1);
        chk("p4_addr1_row0", addr1[31:0], 32'h03020100);
        chk("p4_addr2_row3", addr2[127:96], 32'h03030303);
        chk("p4_tol", {tol1, tol2}, 32'hFFFF0000);
        tick();
        chk("p4_idle_busy", busy, 0);
        chk("p4_idle_valid", out_valid, 0);

        // Planar 8x8: four consecutive beats, last only on the fourth
        push_planar(3); log2_size = 3'd3; cur_l2 = 3;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("p8_valid", out_valid, 1);
            chk("p8_last", out_last, (i == 3) ? 1 : 0);
            if (i == 3) begin
                chk("p8_b3_addr1", addr1[7:0], 4);
                chk("p8_b3_addr2", addr2[7:0], 4);
            end
            tick();
        end
        chk("p8_idle", busy, 0);

        // Angular wrap / clamp at all-ones addresses
        mode_angle = 1'b1; log2_size = 3'd2; cur_l2 = 2; ang_left = 1;
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; ang_addr = '1; ang_tol = 16'hA5C3;
        #1 chk("ang_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("ang_valid", out_valid, 1);
        chk("ang_last", out_last, 1);
`ifdef INTRA_ADDR_CLAMP_EN
        chk("ang_addr1_sat", addr1[7:0], 8);
        chk("ang_addr2_sat", addr2[7:0], 8);
`else
        chk("ang_addr1_raw", addr1[7:0], 255);
        chk("ang_addr2_wrap", addr2[7:0], 0);
`endif
        tick();
        chk("ang_idle", busy, 0);

        // Angular stall: 3 cycles of backpressure after the first beat
        n0 = n_out; mode_angle = 1'b1; log2_size = 3'd3; cur_l2 = 3; ang_left = 4;
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; rand_ang();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_ang();
            #1;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_addr1", addr1, exp_q.size() > 0 ? exp_q[0].addr1 : '1);
            tick();
        end
        out_ready = 1'b1;
        wait_idle(1'b0, 1'b1, "stall");
        chk("stall_beats", n_out - n0, 4);

        // Reset mid-block at beat 10 of a 32x32 planar block
        n0 = n_out; mode_angle = 1'b0; log2_size = 3'd5; cur_l2 = 5; push_planar(5);
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while ((n_out - n0) < 10 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("rst_mid_reached", n_out - n0, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", {addr1[63:0], addr2[63:0]}, 0);
        chk("rst_mid_tol", {tol1, tol2}, 0);
        exp_q.delete();
        #20 rst_n = 1'b1;
        tick();
        chk("rst_rel_idle", {busy, out_valid, in_ready}, 0);
        run_block(vt[6], "rst_restart");

        // Back-to-back: start on last-beat handoff; log2_size=1 treated as 2
        n0 = n_out; mode_angle = 1'b0; log2_size = 3'd3; cur_l2 = 3;
        push_planar(3); push_planar(1);
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (!(out_valid && out_last) && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("b2b_reach_last", {out_valid, out_last}, 2'b11);
        log2_size = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_no_gap", out_valid, 1);
        chk("b2b_single_last", out_last, 1);
        chk("b2b_busy", busy, 1);
        tick();
        chk("b2b_idle", busy, 0);
        chk("b2b_beats", n_out - n0, 5);

        for (int i = 0; i < 11; i++) begin
            run_block(vt[i], $sformatf("vec%0d", i));
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
